// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line, control and frame-status bundle for uart_rx_param
interface uart_rx_param_if #(parameter int DATA_BITS = 8) ();
  logic clken, rx, rdy_clr, stop2, rdy, parity_err, frame_err, overrun, busy;
  logic [1:0] parity_mode;
  logic [DATA_BITS-1:0] data_out;
  modport master(output clken, rx, rdy_clr, parity_mode, stop2,
                 input rdy, data_out, parity_err, frame_err, overrun, busy);
  modport slave(input clken, rx, rdy_clr, parity_mode, stop2,
                output rdy, data_out, parity_err, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote, parity/stop checks and overrun flag
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  uart_rx_param_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] S0 = CW'(OVERSAMPLE/2-1);
  localparam logic [CW-1:0] S1 = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S2 = CW'(OVERSAMPLE/2+1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE-1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS-1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] smp_q, smp_d, pm_q, pm_d;
  logic armed_q, armed_d, s2_q, s2_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic rdy_q, rdy_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic rx_s, vote, mid, last, done, ferr_fin;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign mid = cnt_q == S2;
  assign last = cnt_q == LAST;
  assign ferr_fin = ferr_q | ~vote;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      smp_q <= '0;
      pm_q <= '0;
      armed_q <= 1'b0;
      s2_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      shift_q <= '0;
      data_q <= '0;
      rdy_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      smp_q <= smp_d;
      pm_q <= pm_d;
      armed_q <= armed_d;
      s2_q <= s2_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      shift_q <= shift_d;
      data_q <= data_d;
      rdy_q <= rdy_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      ovr_q <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    smp_d = smp_q;
    pm_d = pm_q;
    armed_d = armed_q;
    s2_d = s2_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    shift_d = shift_q;
    done = 1'b0;
    if (bus.clken) begin
      cnt_d = cnt_q + CW'(1);
      smp_d[0] = cnt_q == S0 ? rx_s : smp_q[0];
      smp_d[1] = cnt_q == S1 ? rx_s : smp_q[1];
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          armed_d = armed_q | rx_s;
          if (armed_q && !rx_s) begin
            state_d = START;
            cnt_d = CW'(1);
            bit_d = '0;
            pm_d = bus.parity_mode;
            s2_d = bus.stop2;
            perr_d = 1'b0;
            ferr_d = 1'b0;
          end
        end
        START: begin
          if (mid && vote) begin
            state_d = IDLE;
            cnt_d = '0;
          end else if (last) state_d = DATA;
        end
        DATA: begin
          if (mid) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (last) begin
            bit_d = bit_q == DB_LAST ? 4'd0 : bit_q + 4'd1;
            if (bit_q == DB_LAST) state_d = ^pm_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          // odd mode inverts the expected bit relative to even
          if (mid) perr_d = vote ^ (^shift_q) ^ pm_q[1];
          if (last) state_d = STOP;
        end
        STOP: begin
          if (mid) begin
            ferr_d = ferr_fin;
            if (bit_q[0] == s2_q) begin
              done = 1'b1;
              state_d = IDLE;
              cnt_d = '0;
              armed_d = ~ferr_fin;
            end
          end
          if (last) bit_d = bit_q + 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    data_d = done ? shift_q : data_q;
    pe_d = done ? perr_q : pe_q;
    fe_d = done ? ferr_fin : fe_q;
    rdy_d = done | (rdy_q & ~bus.rdy_clr);
    ovr_d = ~bus.rdy_clr & (ovr_q | (done & rdy_q));
  end
  assign bus.rdy = rdy_q;
  assign bus.data_out = data_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun = ovr_q;
  assign bus.busy = state_q != IDLE;
endmodule
